if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the program counter, the instruction-memory fetch handshake and the IF/ID pipeline register.
- Consumes the decode stage's Stall/IFWrite, Branch, Jump and JumpAddr.
- Produces PC_id and Instruction_id.
- Inserts NOP bubbles on redirect (flush) and on instruction-memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IFWrite  in  1  1 = IF/PC may advance; 0 = load-use stall, hold PC and IF/ID.
- Branch  in  1  taken conditional branch resolved in ID this cycle.
- Jump  in  1  JAL/JALR resolved in ID this cycle.
- JumpAddr  in  32  redirect target from ID.
- imem_req  out  1  fetch request, valid for imem_addr this cycle.
- imem_addr  out  32  fetch address (= PC_if).
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory returns imem_rdata this cycle (same-cycle response).
- PC_id  out  32  PC of the instruction held in IF/ID.
- Instruction_id  out  32  instruction held in IF/ID.
- Valid_id  out  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0, async):
  - PC_if=RESET_PC, PC_id=RESET_PC, Instruction_id=NOP_INSTR, Valid_id=0, imem_req=0.
  - On deassertion, the first rising edge with rst_n=1 is the first fetch cycle.
- Request generation:
  - imem_req = rst_n_sync_q & IFWrite, where rst_n_sync_q is a flop set to 1 one cycle after reset release.
  - imem_addr = PC_if, combinational, always driven.
- Redirect: redirect = Branch | Jump. Target = {JumpAddr[31:2], 2'b00}; low bits are forced to zero, no misalignment trap.
- Per-edge priority (highest first):
  1. IFWrite=0 (stall): PC_if, PC_id, Instruction_id and Valid_id all hold; redirect ignored (ID re-evaluates it next cycle with the same instruction).
  2. redirect=1: PC_if<=target; Instruction_id<=NOP_INSTR; Valid_id<=0; PC_id<=PC_if. The fetched word is discarded whether or not imem_ready=1.
  3. imem_ready=0 (wait state): PC_if holds; Instruction_id<=NOP_INSTR; Valid_id<=0; PC_id<=PC_if.
  4. Normal: PC_if<=PC_if+4; Instruction_id<=imem_rdata; Valid_id<=1; PC_id<=PC_if.
- Latency: instruction at address A appears in IF/ID one edge after the cycle it is fetched with imem_ready=1.
- Redirect penalty: exactly one bubble. The target is fetched in the cycle after redirect and appears in ID one edge later.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 silently.
- Reset mid-operation: asynchronous reset overrides everything immediately; any in-flight fetch is dropped and no state is retained.
- Assertion (bench only): Branch|Jump while Valid_id=0 is illegal and flagged; the decoder must never redirect on a bubble.

Decomposition:
- Shared package (pipeline_pkg): NOP_INSTR constant, RESET_PC default, XLEN=32.
- Natural sub-module if_id_reg: the IF/ID register with hold (IFWrite=0) and flush-to-NOP inputs. It is reused later for ID/EX with a different payload.
- PC next-state mux and request logic stay in if_stage.

Test Plan:
- Reset release, imem_ready=1, sequential ROM → PC_id 0,4,8,C on successive edges; Instruction_id matches ROM; Valid_id goes 0→1 one edge after first fetch.
- IFWrite=0 for 2 cycles with PC_if=0x10, PC_id=0x0C → PC_if, PC_id and Instruction_id frozen; imem_req=0; fetch resumes at 0x10 with no skipped or duplicated instruction.
- Jump=1, JumpAddr=0x100 while PC_if=0x14 → next edge Instruction_id=0x00000013, Valid_id=0, PC_if=0x100; following edge PC_id=0x100 with ROM[0x100].
- Branch=1 together with IFWrite=0 → nothing changes; next cycle Branch=1, IFWrite=1 → redirect taken.
- imem_ready=0 for 3 cycles at PC_if=0x20 → 3 bubbles (Valid_id=0), PC_if stays 0x20, then Instruction_id=ROM[0x20].
- JumpAddr=0x103 → PC_if=0x100; rst_n pulsed low mid-stream → outputs at reset values within the same cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and the IF/ID payload layout for the RV32I fetch stage.
package if_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Redirect targets are word aligned by dropping the two low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and imem (slave).
// Handshake: imem_req marks imem_addr as a live request; imem_ready=1 in the same
// cycle returns imem_rdata for that address, otherwise the request is retried.
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// Generic pipeline register with hold and flush-to-bubble; payload width is a parameter
// so the same block serves IF/ID and later stages.
module if_stage_if_id_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic [W-1:0] bubble,
  output logic [W-1:0] q
);

  // Hold beats flush: a stalled stage keeps its instruction even if a flush is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (hold) begin
      q <= q;
    end else if (flush) begin
      q <= bubble;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, imem request generation and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_P  = RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR_P = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IFWrite,
  input  logic               Branch,
  input  logic               Jump,
  input  logic [XLEN-1:0]    JumpAddr,
  if_stage_if.master         imem,
  output logic [XLEN-1:0]    PC_id,
  output logic [XLEN-1:0]    Instruction_id,
  output logic               Valid_id
);

  logic            rst_n_sync_q;
  logic [XLEN-1:0] pc_if_q;
  logic            redirect;
  logic            fetch_ok;
  logic [XLEN-1:0] target;
  if_id_t          if_id_d;
  if_id_t          if_id_bubble;
  if_id_t          if_id_q;

  localparam if_id_t IF_ID_RST = '{valid: 1'b0, pc: RESET_PC_P, instr: NOP_INSTR_P};

  // Requests start one cycle after reset release, so the first edge only arms the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_n_sync_q <= 1'b0;
    end else begin
      rst_n_sync_q <= 1'b1;
    end
  end

  assign imem.imem_req  = rst_n_sync_q & IFWrite;
  assign imem.imem_addr = pc_if_q;

  assign redirect = Branch | Jump;
  assign target   = align_word(JumpAddr);
  assign fetch_ok = imem.imem_req & imem.imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_q <= RESET_PC_P;
    end else if (!IFWrite) begin
      pc_if_q <= pc_if_q;
    end else if (redirect) begin
      pc_if_q <= target;
    end else if (fetch_ok) begin
      pc_if_q <= pc_if_q + 32'd4;
    end else begin
      pc_if_q <= pc_if_q;
    end
  end

  // A redirect discards the word fetched this cycle; a missing response also yields a bubble.
  always_comb begin
    if_id_d            = '0;
    if_id_d.valid      = 1'b1;
    if_id_d.pc         = pc_if_q;
    if_id_d.instr      = imem.imem_rdata;
    if_id_bubble       = '0;
    if_id_bubble.valid = 1'b0;
    if_id_bubble.pc    = pc_if_q;
    if_id_bubble.instr = NOP_INSTR_P;
  end

  if_stage_if_id_reg #(
    .W       ($bits(if_id_t)),
    .RST_VAL (IF_ID_RST)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (~IFWrite),
    .flush  (redirect | ~fetch_ok),
    .d      (if_id_d),
    .bubble (if_id_bubble),
    .q      (if_id_q)
  );

  assign PC_id          = if_id_q.pc;
  assign Instruction_id = if_id_q.instr;
  assign Valid_id       = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirects, wait states, reset, PC wrap.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic [31:0] PC_id;
  logic [31:0] Instruction_id;
  logic        Valid_id;

  int total = 0;
  int bad   = 0;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem           (imem_bus),
    .PC_id          (PC_id),
    .Instruction_id (Instruction_id),
    .Valid_id       (Valid_id)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word at address a is 32'hA500_0000 | a
  assign imem_bus.imem_rdata = 32'hA500_0000 | imem_bus.imem_addr;

  // The decoder must never redirect on a bubble
  always @(posedge clk) begin
    if (rst_n && (Branch || Jump) && !Valid_id) begin
      bad++;
      $display("FAIL redirect_on_bubble: Branch=%0b Jump=%0b Valid_id=%0b required Valid_id=1",
               Branch, Jump, Valid_id);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic v, input logic [31:0] addr);
    chk({tag, ".pc_id"}, PC_id, pc);
    chk({tag, ".instr"}, Instruction_id, instr);
    chk({tag, ".valid"}, {31'd0, Valid_id}, {31'd0, v});
    chk({tag, ".addr"}, imem_bus.imem_addr, addr);
  endtask

  initial begin
    rst_n    = 1'b0;
    IFWrite  = 1'b1;
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpAddr = 32'h0;
    imem_bus.imem_ready = 1'b1;
    #12;
    chk_id("reset", 32'h0, 32'h0000_0013, 1'b0, 32'h0);
    chk("reset.req", {31'd0, imem_bus.imem_req}, 32'd0);
    rst_n = 1'b1;

    // First edge only arms the fetch
    step();
    chk("arm.req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk_id("arm", 32'h0, 32'h0000_0013, 1'b0, 32'h0);

    // Sequential fetch
    step(); chk_id("seq0", 32'h0,  32'hA500_0000, 1'b1, 32'h4);
    step(); chk_id("seq1", 32'h4,  32'hA500_0004, 1'b1, 32'h8);
    step(); chk_id("seq2", 32'h8,  32'hA500_0008, 1'b1, 32'hC);
    step(); chk_id("seq3", 32'hC,  32'hA500_000C, 1'b1, 32'h10);

    // Two-cycle load-use stall
    IFWrite = 1'b0;
    #1 chk("stall.req", {31'd0, imem_bus.imem_req}, 32'd0);
    step(); chk_id("stall1", 32'hC, 32'hA500_000C, 1'b1, 32'h10);
    step(); chk_id("stall2", 32'hC, 32'hA500_000C, 1'b1, 32'h10);
    IFWrite = 1'b1;
    step(); chk_id("resume", 32'h10, 32'hA500_0010, 1'b1, 32'h14);

    // Jump to 0x100 from PC_if=0x14
    Jump = 1'b1; JumpAddr = 32'h100;
    step(); chk_id("jump.bubble", 32'h14, 32'h0000_0013, 1'b0, 32'h100);
    Jump = 1'b0;
    step(); chk_id("jump.target", 32'h100, 32'hA500_0100, 1'b1, 32'h104);

    // Branch during stall is ignored, then taken
    Branch = 1'b1; JumpAddr = 32'h200; IFWrite = 1'b0;
    step(); chk_id("br.stalled", 32'h100, 32'hA500_0100, 1'b1, 32'h104);
    IFWrite = 1'b1;
    step(); chk_id("br.taken", 32'h104, 32'h0000_0013, 1'b0, 32'h200);
    Branch = 1'b0;
    step(); chk_id("br.target", 32'h200, 32'hA500_0200, 1'b1, 32'h204);

    // Move to 0x20 then three wait states
    Jump = 1'b1; JumpAddr = 32'h20;
    step(); chk_id("j20", 32'h204, 32'h0000_0013, 1'b0, 32'h20);
    Jump = 1'b0; imem_bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_id("wait", 32'h20, 32'h0000_0013, 1'b0, 32'h20);
    end
    imem_bus.imem_ready = 1'b1;
    step(); chk_id("wait.done", 32'h20, 32'hA500_0020, 1'b1, 32'h24);

    // Misaligned target has its low bits cleared
    Jump = 1'b1; JumpAddr = 32'h103;
    step(); chk_id("mis.bubble", 32'h24, 32'h0000_0013, 1'b0, 32'h100);
    Jump = 1'b0;
    step(); chk_id("mis.target", 32'h100, 32'hA500_0100, 1'b1, 32'h104);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1 chk_id("midrst", 32'h0, 32'h0000_0013, 1'b0, 32'h0);
    chk("midrst.req", {31'd0, imem_bus.imem_req}, 32'd0);
    #3 rst_n = 1'b1;
    step(); chk_id("rearm", 32'h0, 32'h0000_0013, 1'b0, 32'h0);
    step(); chk_id("refetch", 32'h0, 32'hA500_0000, 1'b1, 32'h4);

    // PC wraps from 0xFFFF_FFFC to 0
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    step(); chk_id("wrap.bubble", 32'h4, 32'h0000_0013, 1'b0, 32'hFFFF_FFFC);
    Jump = 1'b0;
    step(); chk_id("wrap.top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0);
    step(); chk_id("wrap.zero", 32'h0, 32'hA500_0000, 1'b1, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
